// File: rtl/axil_img_mem_slv.sv
// axil_img_mem_slv: AXI-Lite responder backed by a single-port word memory.
// Frame buffer targeted by the image read/write masters.
// AW, W and AR each have a one-entry holding register. Write commits and read
// fetches share the one memory port under round-robin arbitration.
// Optional build macro AXIL_IMG_MEM_RANGE_CHK_EN: accesses outside the
// buffer window return SLVERR, do not write memory and read back zero.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1; valid never waits on ready, and a valid response holds
// its payload stable until accepted. All readys here are registers.
module axil_img_mem_slv #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [1:0]                s_axi_bresp,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Protection attributes carry no meaning for a plain frame buffer.
  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Holding registers
  logic                  aw_full, w_full, ar_full;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic [1:0]            aw_resp, ar_resp;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  // 1 = read wins the next contention, 0 = write wins
  logic                  rr_read;

  logic aw_hs, w_hs, ar_hs;
  logic want_w, want_r, grant_w, grant_r;
  logic aw_full_d, w_full_d, ar_full_d;
  logic [1:0] aw_resp_d, ar_resp_d;

  // Byte address to word index; offset bits drop out, upper bits wrap.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> OFF_W);
  endfunction

`ifdef AXIL_IMG_MEM_RANGE_CHK_EN
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * STRB_W);

  // An address below the base underflows into the extra MSB and fails too.
  function automatic logic [1:0] range_resp(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return (off < MEM_BYTES) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  assign aw_resp_d = range_resp(s_axi_awaddr);
  assign ar_resp_d = range_resp(s_axi_araddr);
`else
  assign aw_resp_d = RESP_OKAY;
  assign ar_resp_d = RESP_OKAY;
`endif

  // Handshakes, eligibility, round-robin grant and next hold occupancy
  always_comb begin
    aw_hs     = s_axi_awvalid & s_axi_awready;
    w_hs      = s_axi_wvalid & s_axi_wready;
    ar_hs     = s_axi_arvalid & s_axi_arready;
    want_w    = aw_full & w_full & (~s_axi_bvalid | s_axi_bready);
    want_r    = ar_full & (~s_axi_rvalid | s_axi_rready);
    grant_w   = want_w & (~want_r | ~rr_read);
    grant_r   = want_r & (~want_w | rr_read);
    aw_full_d = aw_hs | (aw_full & ~grant_w);
    w_full_d  = w_hs | (w_full & ~grant_w);
    ar_full_d = ar_hs | (ar_full & ~grant_r);
  end

  // Holds, registered readys, response channels and arbiter pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      aw_idx        <= '0;
      ar_idx        <= '0;
      aw_resp       <= RESP_OKAY;
      ar_resp       <= RESP_OKAY;
      w_data        <= '0;
      w_strb        <= '0;
      rr_read       <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
    end else begin
      if (aw_hs) begin
        aw_idx  <= word_idx(s_axi_awaddr);
        aw_resp <= aw_resp_d;
      end
      if (w_hs) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (ar_hs) begin
        ar_idx  <= word_idx(s_axi_araddr);
        ar_resp <= ar_resp_d;
      end
      aw_full       <= aw_full_d;
      w_full        <= w_full_d;
      ar_full       <= ar_full_d;
      s_axi_awready <= ~aw_full_d;
      s_axi_wready  <= ~w_full_d;
      s_axi_arready <= ~ar_full_d;

      if (grant_w) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= aw_resp;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      if (grant_r) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rresp  <= ar_resp;
        s_axi_rdata  <= (ar_resp == RESP_OKAY) ? mem[ar_idx] : '0;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end

      if (want_w && want_r) begin
        rr_read <= grant_w;
      end
    end
  end

  // Memory write port: byte-enabled, never reset, blocked during reset
  always_ff @(posedge clk) begin
    if (!rst && grant_w && aw_resp == RESP_OKAY) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) begin
          mem[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_img_mem_slv.sv
// tb_axil_img_mem_slv: directed bench for axil_img_mem_slv.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_axil_img_mem_slv;

  logic        clk;
  logic        rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;

  int n_cmp;
  int n_fail;

  axil_img_mem_slv dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Drivers: fixed-length, no checks; callers compare what they return.
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic bv, output logic [1:0] br);
    s_axi_awvalid = 1'b1; s_axi_awaddr = a;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = d; s_axi_wstrb = s;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    bv = s_axi_bvalid; br = s_axi_bresp;
    tick();
  endtask

  task automatic drive_read(input logic [31:0] a, output logic rv,
                            output logic [31:0] rd, output logic [1:0] rr);
    s_axi_arvalid = 1'b1; s_axi_araddr = a;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    rv = s_axi_rvalid; rd = s_axi_rdata; rr = s_axi_rresp;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
         s_axi_bresp, s_axi_rresp, s_axi_rdata} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h expected all zero",
               s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
               s_axi_bresp, s_axi_rresp, s_axi_rdata);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_readys: got %b expected 111",
               {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_basic();
    logic rv; logic [31:0] rd; logic [1:0] rr;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0010_0010;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n_cmp++;
    if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_after_hs: got bv/awr/wr=%b expected 000",
               {s_axi_bvalid, s_axi_awready, s_axi_wready});
    end
    tick();
    n_cmp++;
    if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_bresp: got bv=%b bresp=%b expected bv=1 bresp=00",
               s_axi_bvalid, s_axi_bresp);
    end
    n_cmp++;
    if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
      n_fail++;
      $display("FAIL basic_ready_return: got %b expected 11", {s_axi_awready, s_axi_wready});
    end
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0010_0010;
    tick();
    s_axi_arvalid = 1'b0;
    n_cmp++;
    if ({s_axi_rvalid, s_axi_arready, s_axi_bvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_after_ar: got rv/arr/bv=%b expected 000",
               {s_axi_rvalid, s_axi_arready, s_axi_bvalid});
    end
    tick();
    n_cmp++;
    if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL basic_read: got rv=%b rresp=%b rdata=%h expected 1 00 deadbeef",
               s_axi_rvalid, s_axi_rresp, s_axi_rdata);
    end
    tick();
    // Byte-offset bits are ignored.
    drive_read(32'h0010_0013, rv, rd, rr);
    n_cmp++;
    if ({rv, rr, rd} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL basic_offset_read: got rv=%b rresp=%b rdata=%h expected 1 00 deadbeef",
               rv, rr, rd);
    end
  endtask

  task automatic test_w_first();
    logic bv; logic [1:0] br; logic rv; logic [31:0] rd; logic [1:0] rr;
    drive_write(32'h0010_0020, 32'h0000_0000, 4'hF, bv, br);
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1122_3344; s_axi_wstrb = 4'b0101;
    tick();
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({s_axi_wready, s_axi_bvalid, s_axi_awready} !== 3'b001) begin
        n_fail++;
        $display("FAIL wfirst_hold_%0d: got wr/bv/awr=%b expected 001", i,
                 {s_axi_wready, s_axi_bvalid, s_axi_awready});
      end
      if (i < 2) tick();
    end
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0010_0020;
    tick();
    s_axi_awvalid = 1'b0;
    n_cmp++;
    if (s_axi_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wfirst_b_early: got bv=%b expected 0", s_axi_bvalid);
    end
    tick();
    n_cmp++;
    if ({s_axi_bvalid, s_axi_bresp, s_axi_wready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL wfirst_b: got bv=%b bresp=%b wr=%b expected 1 00 1",
               s_axi_bvalid, s_axi_bresp, s_axi_wready);
    end
    tick();
    drive_read(32'h0010_0020, rv, rd, rr);
    n_cmp++;
    if ({rv, rr, rd} !== {1'b1, 2'b00, 32'h0022_0044}) begin
      n_fail++;
      $display("FAIL wfirst_strobe_data: got rv=%b rresp=%b rdata=%h expected 1 00 00220044",
               rv, rr, rd);
    end
  endtask

  task automatic test_contention();
    logic bv; logic [1:0] br; logic rv; logic [31:0] rd; logic [1:0] rr;
    drive_write(32'h0010_0030, 32'hAAAA_0001, 4'hF, bv, br);
    // First contention: write wins, read sees new data one cycle later.
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0010_0030;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'hBBBB_0002; s_axi_wstrb = 4'hF;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0010_0030;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    tick();
    n_cmp++;
    if ({s_axi_bvalid, s_axi_rvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL cont1_grant: got bv/rv=%b expected 10", {s_axi_bvalid, s_axi_rvalid});
    end
    tick();
    n_cmp++;
    if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'hBBBB_0002}) begin
      n_fail++;
      $display("FAIL cont1_read_new: got rv=%b rdata=%h expected 1 bbbb0002",
               s_axi_rvalid, s_axi_rdata);
    end
    tick(); tick();
    // Second contention: read wins and sees the old data.
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0010_0030;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'hCCCC_0003; s_axi_wstrb = 4'hF;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0010_0030;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    tick();
    n_cmp++;
    if ({s_axi_bvalid, s_axi_rvalid, s_axi_rdata} !== {2'b01, 32'hBBBB_0002}) begin
      n_fail++;
      $display("FAIL cont2_read_first: got bv=%b rv=%b rdata=%h expected 0 1 bbbb0002",
               s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
    end
    tick();
    n_cmp++;
    if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
      n_fail++;
      $display("FAIL cont2_write_second: got bv=%b bresp=%b expected 1 00",
               s_axi_bvalid, s_axi_bresp);
    end
    tick();
    drive_read(32'h0010_0030, rv, rd, rr);
    n_cmp++;
    if ({rv, rd} !== {1'b1, 32'hCCCC_0003}) begin
      n_fail++;
      $display("FAIL cont2_final: got rv=%b rdata=%h expected 1 cccc0003", rv, rd);
    end
  endtask

  task automatic test_b_backpressure();
    logic rv; logic [31:0] rd; logic [1:0] rr;
    s_axi_bready  = 1'b0;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0010_0040;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h1111_1111; s_axi_wstrb = 4'hF;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    // First B pending; second AW/W go straight into the holds.
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0010_0044;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h2222_2222; s_axi_wstrb = 4'hF;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp} !== 5'b00100) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: got awr/wr/bv=%b bresp=%b expected 001 00", i,
                 {s_axi_awready, s_axi_wready, s_axi_bvalid}, s_axi_bresp);
      end
      if (i < 3) tick();
    end
    s_axi_bready = 1'b1;
    tick();
    // Second response loads on the edge the first is accepted.
    n_cmp++;
    if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b111) begin
      n_fail++;
      $display("FAIL bp_second_commit: got bv/awr/wr=%b expected 111",
               {s_axi_bvalid, s_axi_awready, s_axi_wready});
    end
    tick();
    n_cmp++;
    if (s_axi_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got bv=%b expected 0", s_axi_bvalid);
    end
    drive_read(32'h0010_0040, rv, rd, rr);
    n_cmp++;
    if ({rv, rd} !== {1'b1, 32'h1111_1111}) begin
      n_fail++;
      $display("FAIL bp_read_first: got rv=%b rdata=%h expected 1 11111111", rv, rd);
    end
    drive_read(32'h0010_0044, rv, rd, rr);
    n_cmp++;
    if ({rv, rd} !== {1'b1, 32'h2222_2222}) begin
      n_fail++;
      $display("FAIL bp_read_second: got rv=%b rdata=%h expected 1 22222222", rv, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic bv; logic [1:0] br; logic rv; logic [31:0] rd; logic [1:0] rr;
    drive_write(32'h0010_0050, 32'h5555_5555, 4'hF, bv, br);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0010_0050;
    tick();
    s_axi_awvalid = 1'b0;
    n_cmp++;
    if ({s_axi_awready, s_axi_wready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_aw_held: got awr/wr=%b expected 01", {s_axi_awready, s_axi_wready});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_in_reset: got %b expected 0000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid});
    end
    tick();
    n_cmp++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid} !== 4'b1110) begin
      n_fail++;
      $display("FAIL rstmid_after: got rdy/bv=%b expected 1110",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid});
    end
    // A W alone must not pair with the dropped AW.
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h6666_6666; s_axi_wstrb = 4'hF;
    tick();
    s_axi_wvalid = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({s_axi_bvalid, s_axi_awready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_no_b: got bv/awr=%b expected 01", {s_axi_bvalid, s_axi_awready});
    end
    drive_read(32'h0010_0050, rv, rd, rr);
    n_cmp++;
    if ({rv, rd} !== {1'b1, 32'h5555_5555}) begin
      n_fail++;
      $display("FAIL rstmid_mem: got rv=%b rdata=%h expected 1 55555555", rv, rd);
    end
    // Clear the orphaned W hold so later tests start clean.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_range();
    logic bv; logic [1:0] br; logic rv; logic [31:0] rd; logic [1:0] rr;
    drive_write(32'h0010_0000, 32'h0BAD_F00D, 4'hF, bv, br);
    drive_write(32'h0010_0004, 32'h1234_5678, 4'hF, bv, br);
    drive_read(32'h0010_0400, rv, rd, rr);
`ifdef AXIL_IMG_MEM_RANGE_CHK_EN
    n_cmp++;
    if ({rv, rr, rd} !== {1'b1, 2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL range_read_oor: got rv=%b rresp=%b rdata=%h expected 1 10 00000000", rv, rr, rd);
    end
    drive_write(32'h0010_0404, 32'hFFFF_FFFF, 4'hF, bv, br);
    n_cmp++;
    if ({bv, br} !== 3'b110) begin
      n_fail++;
      $display("FAIL range_write_oor: got bv=%b bresp=%b expected 1 10", bv, br);
    end
    drive_read(32'h0010_0004, rv, rd, rr);
    n_cmp++;
    if ({rv, rr, rd} !== {1'b1, 2'b00, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL range_mem_intact: got rv=%b rresp=%b rdata=%h expected 1 00 12345678", rv, rr, rd);
    end
`else
    n_cmp++;
    if ({rv, rr, rd} !== {1'b1, 2'b00, 32'h0BAD_F00D}) begin
      n_fail++;
      $display("FAIL range_read_wrap: got rv=%b rresp=%b rdata=%h expected 1 00 0badf00d", rv, rr, rd);
    end
    drive_write(32'h0010_0404, 32'hFFFF_FFFF, 4'hF, bv, br);
    n_cmp++;
    if ({bv, br} !== 3'b100) begin
      n_fail++;
      $display("FAIL range_write_wrap: got bv=%b bresp=%b expected 1 00", bv, br);
    end
    drive_read(32'h0010_0004, rv, rd, rr);
    n_cmp++;
    if ({rv, rr, rd} !== {1'b1, 2'b00, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL range_mem_wrapped: got rv=%b rresp=%b rdata=%h expected 1 00 ffffffff", rv, rr, rd);
    end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awprot = 3'b000;
    s_axi_wvalid  = 1'b0; s_axi_wdata  = '0; s_axi_wstrb  = '0;
    s_axi_bready  = 1'b1;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arprot = 3'b000;
    s_axi_rready  = 1'b1;
    test_reset();
    test_basic();
    test_w_first();
    test_contention();
    test_b_backpressure();
    test_reset_mid();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
